regfile: RTL and testbench

- Parameterised multi-port register file: one synchronous write port and two asynchronous (combinational) read ports.
- Used as the integer register file of the RV32I core; default configuration is 32 x 32-bit with hard-wired zero register x0.
- Storage is a single array named registers, indexed [0 .. reg_num-1]. Benches may probe it hierarchically as <inst>.registers[j].

---
 rtl/regfile.sv | 84 ++++++++
 tb/tb_regfile.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Integer register file: one synchronous write port, two combinational read ports, optional hard-wired x0.
// Latency: write visible one rising edge later, reads are zero-latency; no backpressure, always accepts.
// REGFILE_BYPASS_EN: when defined, a pending legal write is forwarded combinationally to matching read ports.
`timescale 1ns/1ps
module regfile #(
    parameter int data_width = 32,
    parameter int reg_num    = 32,
    parameter int zeroreg    = 1,
    localparam int AW        = (reg_num > 1) ? $clog2(reg_num) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_n,
    input  logic [AW-1:0]         rs1,
    input  logic [AW-1:0]         rs2,
    input  logic [AW-1:0]         rd,
    input  logic [data_width-1:0] in,
    output logic [data_width-1:0] out1,
    output logic [data_width-1:0] out2
);

    localparam logic [AW:0] REG_LIMIT = (AW + 1)'(reg_num);

    logic [data_width-1:0] registers [reg_num];

    logic rd_in_range;
    logic rs1_in_range;
    logic rs2_in_range;
    logic rd_is_zero_reg;
    logic wr_legal;
    logic wr_fire;

    // Addresses are one bit wider in the compare so a non-power-of-two depth flags its holes.
    assign rd_in_range  = {1'b0, rd}  < REG_LIMIT;
    assign rs1_in_range = {1'b0, rs1} < REG_LIMIT;
    assign rs2_in_range = {1'b0, rs2} < REG_LIMIT;

    generate
        if (zeroreg != 0) begin : g_zero_reg
            assign rd_is_zero_reg = (rd == '0);
        end else begin : g_plain_reg0
            assign rd_is_zero_reg = 1'b0;
        end
    endgenerate

    assign wr_legal = rd_in_range && !rd_is_zero_reg;
    assign wr_fire  = !write_n && wr_legal;

    // x0 is never a write target when hard-wired, so reset alone keeps it at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < reg_num; j++) begin
                registers[j] <= '0;
            end
        end else if (wr_fire) begin
            registers[rd] <= in;
        end
    end

    always_comb begin
        out1 = '0;
        if (rs1_in_range) begin
            out1 = registers[rs1];
        end
`ifdef REGFILE_BYPASS_EN
        if (rst && wr_fire && (rd == rs1)) begin
            out1 = in;
        end
`endif
    end

    always_comb begin
        out2 = '0;
        if (rs2_in_range) begin
            out2 = registers[rs2];
        end
`ifdef REGFILE_BYPASS_EN
        if (rst && wr_fire && (rd == rs2)) begin
            out2 = in;
        end
`endif
    end

endmodule

// File: tb/tb_regfile.sv
// Drives three register-file instances (x0 hard-wired, x0 plain, 20-deep) from shared stimulus
// and compares them against an array model of the architectural register state.
`timescale 1ns/1ps
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        write_n = 1'b1;
    logic [4:0]  rs1     = '0;
    logic [4:0]  rs2     = '0;
    logic [4:0]  rd      = '0;
    logic [31:0] in_dat  = '0;
    logic [31:0] o1 [3];
    logic [31:0] o2 [3];

    regfile #(.data_width(32), .reg_num(32), .zeroreg(1)) dut_a (
        .clk(clk), .rst(rst), .write_n(write_n), .rs1(rs1), .rs2(rs2), .rd(rd),
        .in(in_dat), .out1(o1[0]), .out2(o2[0]));
    regfile #(.data_width(32), .reg_num(32), .zeroreg(0)) dut_b (
        .clk(clk), .rst(rst), .write_n(write_n), .rs1(rs1), .rs2(rs2), .rd(rd),
        .in(in_dat), .out1(o1[1]), .out2(o2[1]));
    regfile #(.data_width(32), .reg_num(20), .zeroreg(1)) dut_c (
        .clk(clk), .rst(rst), .write_n(write_n), .rs1(rs1), .rs2(rs2), .rd(rd),
        .in(in_dat), .out1(o1[2]), .out2(o2[2]));

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model [3][32];
    int          nregs [3] = '{32, 32, 20};
    bit          zr    [3] = '{1'b1, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit write_ok(int k);
        return rst && !write_n && (int'(rd) < nregs[k]) && !(zr[k] && rd == 0);
    endfunction

    function automatic logic [31:0] mread(int k, int a);
        if (a >= nregs[k]) return '0;
        if (zr[k] && a == 0) return '0;
        if (BYP && write_ok(k) && a == int'(rd)) return in_dat;
        return model[k][a];
    endfunction

    function automatic logic [31:0] dut_reg(int k, int j);
        case (k)
            0:       return dut_a.registers[j];
            1:       return dut_b.registers[j];
            default: return (j < 20) ? dut_c.registers[j] : 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 32; j++) model[k][j] = '0;
    endtask

    task automatic step();
        #1 clk = 1'b1;
        for (int k = 0; k < 3; k++)
            if (write_ok(k)) model[k][rd] = in_dat;
        #4 clk = 1'b0;
        #5;
    endtask

    task automatic check_outs(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_out1_i%0d_a%0d", tag, k, rs1), o1[k], mread(k, int'(rs1)));
            check($sformatf("%s_out2_i%0d_a%0d", tag, k, rs2), o2[k], mread(k, int'(rs2)));
        end
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < nregs[k]; j++)
                check($sformatf("%s_reg_i%0d_r%0d", tag, k, j), dut_reg(k, j), model[k][j]);
    endtask

    initial begin
        int addrs [3] = '{1, 4, 5};

        // Asynchronous reset with the clock idle.
        #5 rst = 1'b0;
        model_reset();
        #2;
        check_regs("rst");
        check_outs("rst");
        rst = 1'b1;
        #3;

        // Basic write/read.
        write_n = 1'b0; rd = 5'd1; in_dat = 32'h100; rs1 = 5'd1; rs2 = 5'd2;
        step();
        write_n = 1'b1;
        #1;
        check("wr1_out1", o1[0], 32'h0000_0100);
        check("wr1_out2", o2[0], 32'h0);
        repeat (10) step();
        check("wr1_hold", dut_a.registers[1], 32'h100);

        // Second write pair.
        write_n = 1'b0; rd = 5'd5; in_dat = 32'h12345;
        step();
        rd = 5'd4; in_dat = 32'hdeadbeef;
        step();
        write_n = 1'b1; rs1 = 5'd1; rs2 = 5'd5;
        #1;
        check("wr2_out1", o1[0], 32'h100);
        check("wr2_out2", o2[0], 32'h0001_2345);
        check("wr2_reg4", dut_a.registers[4], 32'hdeadbeef);
        check_regs("wr2");

        // Zero register, hard-wired versus plain.
        write_n = 1'b0; rd = 5'd0; in_dat = 32'h12345; rs1 = 5'd0; rs2 = 5'd4;
        #1 check_outs("zero_pre");
        step();
        write_n = 1'b1;
        #1;
        check("zero_out1_hw", o1[0], 32'h0);
        check("zero_reg0_hw", dut_a.registers[0], 32'h0);
        check("zero_out2_hw", o2[0], 32'hdeadbeef);
        check("zero_out1_plain", o1[1], 32'h0001_2345);

        // Hold with write disabled while data toggles.
        for (int i = 0; i < 10; i++) begin
            in_dat = $urandom;
            rd = 5'($urandom_range(0, 31));
            step();
        end
        check_regs("hold");

        // Combinational read follows the address with no clock.
        for (int i = 0; i < 3; i++) begin
            rs1 = 5'(addrs[i]);
            #1 check($sformatf("comb_out1_a%0d", addrs[i]), o1[0], model[0][addrs[i]]);
        end

        // Reset between edges, with a write attempted while held.
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("rstmid_reg1", dut_a.registers[1], 32'h0);
        check("rstmid_reg4", dut_a.registers[4], 32'h0);
        check("rstmid_reg5", dut_a.registers[5], 32'h0);
        write_n = 1'b0; rd = 5'd7; in_dat = 32'hcafe_f00d; rs1 = 5'd7;
        #1 check_outs("rstmid_wr_pre");
        step();
        check_regs("rstmid_wr");
        rst = 1'b1; write_n = 1'b1;
        #1;

        // Write-through while the edge is pending.
        rd = 5'd3; rs1 = 5'd3; rs2 = 5'd3; in_dat = 32'ha5a5a5a5; write_n = 1'b0;
        #1 check("byp_out1", o1[0], BYP ? 32'ha5a5a5a5 : 32'h0);
        check_outs("byp");
        step();
        write_n = 1'b1;
        #1 check("byp_post", o1[0], 32'ha5a5a5a5);

        // Out-of-range write and read on the 20-deep instance.
        rd = 5'd25; rs1 = 5'd25; rs2 = 5'd19; in_dat = 32'h0000_ffff; write_n = 1'b0;
        #1 check("oor_out1_pre", o1[2], 32'h0);
        step();
        write_n = 1'b1;
        #1 check("oor_out1_post", o1[2], 32'h0);
        check_regs("oor");

        // Randomised traffic with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            write_n = ($urandom_range(0, 3) == 0);
            rd      = 5'($urandom_range(0, 31));
            rs1     = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2     = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            in_dat  = $urandom;
            #1 check_outs("rnd_pre");
            step();
            check_outs("rnd_post");
            if (i % 40 == 39) check_regs("rnd");
            if (i % 97 == 96) begin
                rst = 1'b0;
                model_reset();
                #1 check_outs("rnd_rst");
                rst = 1'b1;
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
